// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: transmit holding FIFO between THR writes and the UART
// transmitter. It hands bytes out over a TX_start/TX_done handshake and
// produces the THRE/TEMT status bits and the THRE interrupt code.
module uart_tx_buffer #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          WR,
  input  logic [7:0]    dataIn,
  input  logic [7:0]    FCR,
  input  logic [7:0]    IER,
  input  logic          TX_done,
  output logic [7:0]    dataOut,
  output logic          TX_start,
  output logic [7:0]    LSR,
  output logic [7:0]    IIR,
  output logic [AW:0]   count
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e        state_q, state_d;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [7:0]    dout_q, dout_d;
  logic          start_q, start_d;
  logic          fen_q;

  logic          flush, pop, push, thre, temt;
  logic [AW:0]   cap;

  // Remaining control bits have no transmit-side meaning.
  logic          unused_bits;
  assign unused_bits = ^{FCR[7:3], FCR[1], IER[7:2], IER[0]};

  // Flush/pop/push decisions, pointer/count update and handshake next state.
  always_comb begin
    cap     = FCR[0] ? (AW+1)'(DEPTH) : (AW+1)'(1);
    // Toggling FIFO enable empties the queue just like an explicit clear.
    flush   = FCR[2] | (FCR[0] ^ fen_q);
    pop     = (state_q == IDLE) && (cnt_q != '0) && !flush;
    // A pop frees a slot in the same cycle, so a write to a full FIFO still lands.
    push    = WR && !flush && ((cnt_q < cap) || pop);

    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    dout_d  = dout_q;
    start_d = 1'b0;

    if (flush) begin
      rptr_d = '0;
      wptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (pop)  rptr_d = rptr_q + AW'(1);
      if (push) wptr_d = wptr_q + AW'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end

    // An in-flight frame is never aborted by a flush; only TX_done ends BUSY.
    case (state_q)
      IDLE: if (pop) begin
        state_d = BUSY;
        dout_d  = mem_q[rptr_q];
        start_d = 1'b1;
      end
      BUSY: if (TX_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, pointers, count and handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rptr_q  <= '0;
      wptr_q  <= '0;
      cnt_q   <= '0;
      dout_q  <= 8'h00;
      start_q <= 1'b0;
      fen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      start_q <= start_d;
      fen_q   <= FCR[0];
    end
  end

  // Byte storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= dataIn;
  end

  assign thre     = (cnt_q == '0);
  assign temt     = thre && (state_q == IDLE);
  assign LSR      = {1'b0, temt, thre, 5'b0};
  assign IIR      = (IER[1] && thre) ? 8'h02 : 8'h01;
  assign dataOut  = dout_q;
  assign TX_start = start_q;
  assign count    = cnt_q;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Bench for uart_tx_buffer: directed scenarios plus random traffic, checked
// every cycle against a queue-based behavioural model.
module tb_uart_tx_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic       WR;
  logic [7:0] dataIn, FCR, IER;
  logic       TX_done;
  logic [7:0] dataOut, LSR, IIR;
  logic       TX_start;
  logic [5:0] count;

  uart_tx_buffer #(.DEPTH(32), .AW(5)) dut (
    .clk(clk), .reset(reset), .WR(WR), .dataIn(dataIn), .FCR(FCR), .IER(IER),
    .TX_done(TX_done), .dataOut(dataOut), .TX_start(TX_start), .LSR(LSR),
    .IIR(IIR), .count(count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  // reference model state
  logic [7:0] m_q [$];
  bit         m_busy;
  logic [7:0] m_dout;
  bit         m_start;
  bit         m_fen;
  logic [7:0] obs [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_busy  = 0;
    m_dout  = 8'h00;
    m_start = 0;
    m_fen   = 0;
  endtask

  // One clock of behaviour, from the inputs about to be sampled.
  task automatic model_step();
    bit fl, pp;
    int cap;
    if (reset) begin model_reset(); return; end
    fl  = FCR[2] || (FCR[0] != m_fen);
    cap = FCR[0] ? 32 : 1;
    pp  = !m_busy && m_q.size() > 0 && !fl;
    m_start = 0;
    if (fl) m_q.delete();
    else begin
      if (pp) begin m_dout = m_q.pop_front(); m_start = 1; end
      if (WR && m_q.size() < cap) m_q.push_back(dataIn);
    end
    if (pp) m_busy = 1;
    else if (m_busy && TX_done) m_busy = 0;
    m_fen = FCR[0];
  endtask

  function automatic logic [7:0] exp_lsr();
    bit e = (m_q.size() == 0);
    return {1'b0, e && !m_busy, e, 5'b0};
  endfunction

  task automatic cyc();
    model_step();
    @(posedge clk); #1;
    chk("count", 32'(count), 32'(m_q.size()));
    chk("dataOut", 32'(dataOut), 32'(m_dout));
    chk("TX_start", 32'(TX_start), 32'(m_start));
    chk("LSR", 32'(LSR), 32'(exp_lsr()));
    chk("IIR", 32'(IIR), (IER[1] && m_q.size() == 0) ? 32'h02 : 32'h01);
    if (TX_start) obs.push_back(dataOut);
  endtask

  task automatic wr_byte(input logic [7:0] b);
    WR = 1; dataIn = b; cyc(); WR = 0;
  endtask

  task automatic done_pulse();
    TX_done = 1; cyc(); TX_done = 0;
  endtask

  initial begin
    reset = 1; WR = 0; dataIn = 0; FCR = 8'h01; IER = 8'h02; TX_done = 0;
    model_reset();
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_LSR", 32'(LSR), 32'h60);
    chk("rst_IIR", 32'(IIR), 32'h02);
    chk("rst_start", 32'(TX_start), 0);
    cyc(); cyc();
    reset = 0;

    // idle: nothing queued, no start
    obs.delete();
    repeat (6) cyc();
    chk("idle_starts", 32'(obs.size()), 0);
    chk("idle_LSR", 32'(LSR), 32'h60);

    // single byte, latency and status while busy
    wr_byte(8'hA5);
    chk("a5_cnt1", 32'(count), 1);
    cyc();
    chk("a5_start", 32'(TX_start), 1);
    chk("a5_dout", 32'(dataOut), 32'hA5);
    chk("a5_busy_LSR", 32'(LSR), 32'h20);
    repeat (9) cyc();
    done_pulse();
    chk("a5_done_LSR", 32'(LSR), 32'h60);
    cyc();

    // 33 bytes against a stalled transmitter
    obs.delete();
    for (int i = 0; i < 33; i++) wr_byte(8'(i));
    chk("fill_cnt", 32'(count), 32);
    for (int i = 0; i < 33; i++) begin done_pulse(); cyc(); cyc(); end
    chk("fill_nout", 32'(obs.size()), 33);
    for (int i = 0; i < 33 && i < obs.size(); i++) chk("fill_order", 32'(obs[i]), 32'(i));

    // character mode: one holding slot
    FCR = 8'h00; repeat (3) cyc();
    obs.delete();
    wr_byte(8'h11); wr_byte(8'h22); wr_byte(8'h33);
    chk("chr_cnt", 32'(count), 1);
    repeat (3) begin done_pulse(); repeat (3) cyc(); end
    chk("chr_nout", 32'(obs.size()), 2);
    if (obs.size() == 2) begin
      chk("chr_b0", 32'(obs[0]), 32'h11);
      chk("chr_b1", 32'(obs[1]), 32'h22);
    end

    // FCR[2] clear during a frame
    FCR = 8'h01; repeat (3) cyc();
    for (int i = 0; i < 5; i++) wr_byte(8'h40 + 8'(i));
    chk("fl_cnt4", 32'(count), 4);
    obs.delete();
    FCR = 8'h05; cyc(); FCR = 8'h01;
    chk("fl_cnt0", 32'(count), 0);
    repeat (3) cyc();
    done_pulse();
    repeat (5) cyc();
    chk("fl_nostart", 32'(obs.size()), 0);
    chk("fl_IIR", 32'(IIR), 32'h02);

    // asynchronous reset while busy
    for (int i = 0; i < 5; i++) wr_byte(8'h80 + 8'(i));
    chk("ar_cnt4", 32'(count), 4);
    #2 reset = 1; #1;
    chk("ar_start", 32'(TX_start), 0);
    chk("ar_cnt", 32'(count), 0);
    chk("ar_LSR", 32'(LSR), 32'h60);
    model_reset();
    cyc(); reset = 0; cyc(); cyc();
    wr_byte(8'h5A); cyc();
    chk("ar_restart", 32'(TX_start), 1);
    chk("ar_dout", 32'(dataOut), 32'h5A);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      WR      = ($urandom_range(0, 2) != 0);
      dataIn  = 8'($urandom);
      TX_done = m_busy ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 299) == 0) FCR[0] = ~FCR[0];
      FCR[2]  = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 49) == 0) IER[1] = ~IER[1];
      cyc();
    end
    WR = 0; TX_done = 0; FCR[2] = 0;
    cyc();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffer.md
# uart_tx_buffer

Transmit-side holding FIFO of the UART, sitting between the APB register interface (THR writes) and the UART transmitter shift logic. It queues up to DEPTH bytes written by the processor and hands them one at a time to the transmitter over a start/done handshake. It also produces the transmit-related bits of LSR (THRE, TEMT) and the THRE interrupt code in IIR.

## Interface
- DEPTH, 32, FIFO capacity in bytes when FIFO mode is enabled (power of two).
- AW, 5, pointer width, log2(DEPTH).
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- WR  in  1  THR write strobe from the APB block; one byte per cycle while high.
- dataIn  in  8  byte to enqueue, sampled when WR=1.
- FCR  in  8  FIFO control. Bit 0 is FIFO enable. Bit 2 clears the TX FIFO while high.
- IER  in  8  interrupt enable. Bit 1 enables the THRE interrupt.
- TX_done  in  1  one-cycle pulse from the transmitter when the stop bit of the current frame ends.
- dataOut  out  8  byte presented to the transmitter; held stable from TX_start until the next load.
- TX_start  out  1  one-cycle pulse; the transmitter latches dataOut and begins a frame.
- LSR  out  8  bit 5 = THRE, bit 6 = TEMT, all other bits 0.
- IIR  out  8  8'h02 when a THRE interrupt is pending, else 8'h01.
- count  out  AW+1  current number of queued bytes (0..DEPTH).

## Operation
- Storage is a circular buffer with read pointer, write pointer and count. Pointers wrap modulo DEPTH.
- Effective capacity:
  - DEPTH when FCR[0]=1.
  - 1 when FCR[0]=0 (character mode).
- Enqueue: WR=1 and count < capacity writes dataIn at the write pointer, then advances the pointer and count.
- WR when full: the byte is silently dropped. There is no TX overrun flag.
- Flush: FCR[2]=1, or FCR[0] differing from its value on the previous cycle.
  - Pointers and count go to 0.
  - WR in the same cycle is dropped.
  - A frame already in flight is not aborted.
- Handshake FSM, two states:
  - IDLE: if count != 0 and no flush is active, load the head byte into dataOut, advance the read pointer, decrement count, set TX_start=1 for the next cycle, and go to BUSY.
  - BUSY: wait for TX_done=1, then go to IDLE. TX_start is high only during the first BUSY cycle.
  - TX_done in IDLE is ignored.
- Simultaneous enqueue and dequeue: both take effect and count is unchanged. A write to a full FIFO in the same cycle as a pop is accepted.
- LSR and IIR are combinational from current count/state/IER, so they never lag count:
  - THRE = (count == 0).
  - TEMT = (count == 0 && state == IDLE).
  - IIR = 8'h02 if IER[1] && count == 0, else 8'h01. The interrupt clears by writing THR or clearing IER[1].

## Timing
- Reset values:
  - dataOut = 8'h00, TX_start = 0, count = 0, state IDLE, pointers 0.
  - LSR = 8'h60, IIR = 8'h01 (8'h02 if IER[1]=1).
- Write-to-start latency into an empty, idle FIFO:
  - WR sampled at edge N; count = 1 after N.
  - IDLE pops at edge N+1; dataOut is valid and TX_start = 1 during cycle N+1..N+2; count = 0.
- Back-to-back frames: TX_done sampled at edge M moves the FSM to IDLE. The next pop happens at M+1, with TX_start high during M+1..M+2. There is a one-idle-cycle gap per frame.
- A flush asserted in the same cycle the FSM would pop suppresses the pop.
- reset mid-frame forces IDLE and TX_start = 0 asynchronously; contents are lost.

## Test plan
- Reset then idle, IER=8'h02 -> LSR = 8'h60, IIR = 8'h02, TX_start never pulses, count = 0.
- FCR=8'h01; write 8'hA5 once; pulse TX_done 10 cycles after TX_start -> TX_start exactly one cycle after count becomes 1, dataOut = 8'hA5. LSR = 8'h20 while BUSY, 8'h60 after TX_done.
- FCR=8'h01, transmitter stalled; write 33 bytes 8'h00..8'h20 -> the first byte is popped to the transmitter immediately. Count saturates at 32, with the 33rd byte 8'h20 fitting because one entry was popped. Release TX_done repeatedly -> output order 8'h00..8'h20, no loss.
- FCR=8'h00 (character mode); write 8'h11, 8'h22, 8'h33 on consecutive cycles while BUSY -> only 8'h22 is held (first popped, third dropped); outputs 8'h11 then 8'h22.
- Five bytes queued, pulse FCR[2] for one cycle during a frame -> count = 0 next cycle. The current frame completes on TX_done, then no further TX_start. IIR = 8'h02 when IER[1] = 1.
- Assert reset while BUSY with 4 queued -> immediately TX_start = 0, count = 0, LSR = 8'h60. After release, a single write produces a normal start.
